stack_sequencer: RTL and testbench

Sequences all stack traffic for the CPU core: PUSH/POP of single nibbles and the three-nibble CALL/RET return-address transfers. It owns the 8-bit stack pointer and requests the shared 4-bit data RAM port through the existing RAM arbiter. The core issues one operation per valid/ready handshake and receives a `done` pulse carrying any popped data. This replaces the per-instruction SP/RAM micro-steps that were previously hard-coded in the core.

---
 rtl/stack_sequencer_if.sv | 35 +++
 rtl/stack_sequencer.sv | 115 +++++++++++
 tb/tb_stack_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_sequencer_if.sv
// Core/arbiter-facing bundle for the stack sequencer.
// master = core plus RAM arbiter side, slave = sequencer side.
interface stack_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [11:0] req_data;
  logic        sp_wr_en;
  logic [7:0]  sp_wr_data;
  logic [7:0]  sp;
  logic        ram_req;
  logic        ram_grant;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [3:0]  ram_wdata;
  logic [3:0]  ram_rdata;
  logic        done;
  logic [11:0] rsp_data;

  modport master (
    output req_valid, req_op, req_data,
    output sp_wr_en, sp_wr_data,
    output ram_grant, ram_rdata,
    input  req_ready, sp, ram_req, ram_addr,
    input  ram_we, ram_wdata, done, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_data,
    input  sp_wr_en, sp_wr_data,
    input  ram_grant, ram_rdata,
    output req_ready, sp, ram_req, ram_addr,
    output ram_we, ram_wdata, done, rsp_data
  );
endinterface

// File: rtl/stack_sequencer.sv
// Stack sequencer: PUSH/POP nibbles and 3-nibble CALL/RET
// transfers through the shared RAM port; owns the stack pointer.
module stack_sequencer #(
  parameter logic [3:0] STACK_PAGE = 4'h0
) (
  input logic clk,
  input logic reset,
  stack_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    READ,
    DONE
  } state_t;

  state_t      state;
  logic [1:0]  op;
  logic [1:0]  idx;
  logic [11:0] data;
  logic [11:0] rbuf;
  logic [11:0] rsp;
  logic [7:0]  sp_q;
  logic [7:0]  spm1;
  logic        is_wr;
  logic        last;
  logic        acc;
  logic [3:0]  wnib;
  logic [11:0] nbuf;

  assign is_wr = ~op[0];
  assign last  = ~op[1] | (idx == 2'd2);
  assign spm1  = sp_q - 8'd1;
  assign acc   = (state == ACCESS);

  // CALL writes high nibble first so PCSL lands lowest
  always_comb begin
    wnib = data[3:0];
    if (op[1]) begin
      unique case (idx)
        2'd0:    wnib = data[11:8];
        2'd1:    wnib = data[7:4];
        default: wnib = data[3:0];
      endcase
    end
  end

  always_comb begin
    nbuf = rbuf;
    unique case (idx)
      2'd0:    nbuf[3:0]  = bus.ram_rdata;
      2'd1:    nbuf[7:4]  = bus.ram_rdata;
      default: nbuf[11:8] = bus.ram_rdata;
    endcase
  end

  assign bus.req_ready = (state == IDLE) & ~bus.sp_wr_en;
  assign bus.ram_req   = acc;
  assign bus.ram_we    = acc & is_wr;
  assign bus.ram_addr  = acc ? {STACK_PAGE, is_wr ? spm1 : sp_q}
                             : 12'h000;
  assign bus.ram_wdata = (acc & is_wr) ? wnib : 4'h0;
  assign bus.done      = (state == DONE);
  assign bus.sp        = sp_q;
  assign bus.rsp_data  = rsp;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op    <= 2'd0;
      idx   <= 2'd0;
      data  <= 12'h000;
      rbuf  <= 12'h000;
      rsp   <= 12'h000;
      sp_q  <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.sp_wr_en) begin
            sp_q <= bus.sp_wr_data;
          end else if (bus.req_valid) begin
            state <= ACCESS;
            op    <= bus.req_op;
            data  <= bus.req_data;
            idx   <= 2'd0;
            rbuf  <= 12'h000;
          end
        end
        ACCESS: begin
          if (bus.ram_grant) begin
            if (is_wr) begin
              sp_q <= spm1;
              if (last) state <= DONE;
              else      idx   <= idx + 2'd1;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          sp_q <= sp_q + 8'd1;
          rbuf <= nbuf;
          if (last) begin
            rsp   <= nbuf;
            state <= DONE;
          end else begin
            idx   <= idx + 2'd1;
            state <= ACCESS;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer: directed table,
// hand-written corner sequences and randomized ops vs a reference model.
module tb_stack_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stack_sequencer_if bus ();

  stack_sequencer #(.STACK_PAGE(4'h0)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  logic [3:0] mem [4096];
  logic [3:0] ref_mem [4096];
  logic [7:0] ref_sp;
  logic [11:0] ref_rsp;
  int wrcnt = 0;
  int ncmp = 0;
  int nerr = 0;

  // Arbiter-side RAM: commits only on granted edges
  always @(posedge clk) begin
    if (bus.ram_req && bus.ram_grant) begin
      if (bus.ram_we) begin
        mem[bus.ram_addr] <= bus.ram_wdata;
        wrcnt <= wrcnt + 1;
      end else begin
        bus.ram_rdata <= mem[bus.ram_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  // Reference: stack semantics and access schedule, no state machine
  task automatic model_op(input logic [1:0] op, input logic [11:0] d,
                          input logic [63:0] gp, output int n,
                          output logic [11:0] r, output int nw);
    int t;
    int k;
    logic [3:0] nib [3];
    k = op[1] ? 3 : 1;
    nw = 0;
    if (!op[0]) begin
      nib[0] = op[1] ? d[11:8] : d[3:0];
      nib[1] = d[7:4];
      nib[2] = d[3:0];
      for (int i = 0; i < k; i++) begin
        ref_sp = ref_sp - 8'd1;
        ref_mem[{4'h0, ref_sp}] = nib[i];
        nw++;
      end
    end else begin
      ref_rsp = 12'h000;
      for (int i = 0; i < k; i++) begin
        ref_rsp = ref_rsp | (12'(ref_mem[{4'h0, ref_sp}]) << (4 * i));
        ref_sp = ref_sp + 8'd1;
      end
    end
    r = ref_rsp;
    t = 1;
    for (int i = 0; i < k; i++) begin
      while (!gp[t] && t < 60) t++;
      t += op[0] ? 2 : 1;
    end
    n = t;
  endtask

  task automatic set_sp(input logic [7:0] v);
    bus.sp_wr_en = 1'b1;
    bus.sp_wr_data = v;
    @(posedge clk);
    #1 bus.sp_wr_en = 1'b0;
    @(negedge clk);
    chk("sp_load", bus.sp, v);
    ref_sp = v;
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE
  task automatic run_op(input string nm, input logic [1:0] op,
                        input logic [11:0] d, input logic [63:0] gp,
                        input int en, input logic [11:0] er,
                        input logic [7:0] es, input int ew);
    int t;
    int got;
    int w0;
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_data = d;
    bus.ram_grant = 1'b0;
    #1 chk({nm, "_ready_idle"}, bus.req_ready, 1'b1);
    w0 = wrcnt;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    t = 1;
    got = 0;
    while (t < 64 && got == 0) begin
      bus.ram_grant = gp[t];
      @(negedge clk);
      if (bus.done) begin
        got = t;
      end else begin
        if (t == 1) chk({nm, "_ready_busy"}, bus.req_ready, 1'b0);
        @(posedge clk);
        #1 t++;
      end
    end
    chk({nm, "_latency"}, got, en);
    chk({nm, "_rsp"}, bus.rsp_data, er);
    chk({nm, "_sp"}, bus.sp, es);
    chk({nm, "_writes"}, wrcnt - w0, ew);
    bus.ram_grant = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    string       nm;
    logic [1:0]  op;
    logic [11:0] d;
    int          spw;
    logic [63:0] gp;
    int          n;
    logic [11:0] rsp;
    logic [7:0]  sp;
    int          nw;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int n;
    int nw;
    int bad;
    int w0;
    logic [11:0] r;
    logic [1:0] op;
    logic [11:0] d;
    logic [63:0] gp;

    tbl[0] = '{"pop", 2'b01, 12'h000, 8'h40, '1, 3, 12'h00A, 8'h41, 0};
    tbl[1] = '{"push", 2'b00, 12'h007, 8'h10, 64'hFFFF_FFFF_FFFF_FFF8,
               4, 12'h00A, 8'h0F, 1};
    tbl[2] = '{"call", 2'b10, 12'h5C7, 8'h02, '1, 4, 12'h00A, 8'hFF, 3};
    tbl[3] = '{"ret", 2'b11, 12'h000, -1, '1, 7, 12'h5C7, 8'h02, 0};

    for (int i = 0; i < 4096; i++) begin
      mem[i] = 4'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[12'h040] = 4'hA;
    ref_mem[12'h040] = 4'hA;
    ref_sp = 8'h00;
    ref_rsp = 12'h000;

    bus.req_valid = 1'b0;
    bus.req_op = 2'b00;
    bus.req_data = 12'h000;
    bus.sp_wr_en = 1'b0;
    bus.sp_wr_data = 8'h00;
    bus.ram_grant = 1'b0;
    bus.ram_rdata = 4'h0;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_sp", bus.sp, 8'h00);
    chk("rst_ram_req", bus.ram_req, 1'b0);
    chk("rst_ram_we", bus.ram_we, 1'b0);
    chk("rst_ram_addr", bus.ram_addr, 12'h000);
    chk("rst_ram_wdata", bus.ram_wdata, 4'h0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_rsp", bus.rsp_data, 12'h000);
    chk("rst_ready", bus.req_ready, 1'b1);

    for (int i = 0; i < 4; i++) begin
      if (tbl[i].spw >= 0) set_sp(8'(tbl[i].spw));
      model_op(tbl[i].op, tbl[i].d, tbl[i].gp, n, r, nw);
      run_op(tbl[i].nm, tbl[i].op, tbl[i].d, tbl[i].gp,
             tbl[i].n, tbl[i].rsp, tbl[i].sp, tbl[i].nw);
    end
    chk("call_mem_001", mem[12'h001], 4'h5);
    chk("call_mem_000", mem[12'h000], 4'hC);
    chk("call_mem_0ff", mem[12'h0FF], 4'h7);
    chk("push_mem_00f", mem[12'h00F], 4'h7);

    // SP load and request in the same IDLE cycle
    bus.sp_wr_en = 1'b1;
    bus.sp_wr_data = 8'h80;
    bus.req_valid = 1'b1;
    bus.req_op = 2'b00;
    bus.req_data = 12'h003;
    #1 chk("spwr_ready_low", bus.req_ready, 1'b0);
    @(posedge clk);
    #1 bus.sp_wr_en = 1'b0;
    @(negedge clk);
    chk("spwr_sp", bus.sp, 8'h80);
    ref_sp = 8'h80;
    model_op(2'b00, 12'h003, '1, n, r, nw);
    run_op("spwr_push", 2'b00, 12'h003, '1, 2, 12'h5C7, 8'h7F, 1);
    chk("spwr_mem_07f", mem[12'h07F], 4'h3);

    // Reset one cycle after the first CALL write
    set_sp(8'h02);
    w0 = wrcnt;
    bus.req_valid = 1'b1;
    bus.req_op = 2'b10;
    bus.req_data = 12'h9AB;
    bus.ram_grant = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 bus.ram_grant = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rstcall_mid_sp", bus.sp, 8'h01);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rstcall_sp", bus.sp, 8'h00);
    chk("rstcall_ram_req", bus.ram_req, 1'b0);
    chk("rstcall_ready", bus.req_ready, 1'b1);
    chk("rstcall_rsp", bus.rsp_data, 12'h000);
    bus.ram_grant = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done || bus.ram_req) bad++;
    end
    bus.ram_grant = 1'b0;
    chk("rstcall_quiet", bad, 0);
    chk("rstcall_writes", wrcnt - w0, 1);
    chk("rstcall_mem_001", mem[12'h001], 4'h9);
    chk("rstcall_mem_000", mem[12'h000], 4'hC);
    ref_mem[12'h001] = 4'h9;
    ref_sp = 8'h00;
    ref_rsp = 12'h000;

    // Randomized ops with random grant denial
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) set_sp(8'($urandom));
      op = 2'($urandom);
      d = 12'($urandom);
      gp = {$urandom, $urandom} | {$urandom, $urandom};
      gp[63:50] = '1;
      model_op(op, d, gp, n, r, nw);
      run_op($sformatf("rnd%0d", i), op, d, gp, n, r, ref_sp, nw);
    end

    bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) bad++;
    chk("stack_page_contents", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
